// File: rtl/vote_pkg.sv
// Shared types and width helpers for the sequential vote tally.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Bits needed to hold the values 0..n, never less than one bit.
    function automatic int clog2_cnt(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // The timer only has to reach TIMEOUT-1 before the session is forced closed.
    function automatic int timer_w(input int timeout);
        return clog2_cnt(timeout - 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of a W-bit vector.
module vote_popcount
    import vote_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0]               i_vec,
    output logic [clog2_cnt(W)-1:0]    o_cnt
);

    localparam int CW = clog2_cnt(W);

    logic [CW-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < W; i++) begin
            w_sum = w_sum + CW'(i_vec[i]);
        end
    end

    assign o_cnt = w_sum;

endmodule

// File: rtl/vote_tally_fsm.sv
// Sequential N-voter tally: opens a session on start, counts one vote per voter,
// decides early, on exhaustion of the pass, or on timeout, and holds the result.
module vote_tally_fsm
    import vote_pkg::*;
#(
    parameter int N_VOTERS = 5,
    parameter int THRESH   = 3,
    parameter int TIMEOUT  = 1000,
    localparam int CNT_W   = clog2_cnt(N_VOTERS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_req,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timed_out,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic [CNT_W-1:0]    no_cnt,
    output logic [N_VOTERS-1:0] voted
);

    localparam int                 TIMER_W = timer_w(TIMEOUT);
    localparam logic [CNT_W-1:0]   THR     = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0]   NO_MAX  = CNT_W'(N_VOTERS - THRESH);
    localparam logic [TIMER_W-1:0] T_LAST  = TIMER_W'(TIMEOUT - 1);

    state_t              r_state, w_state_n;
    logic [TIMER_W-1:0]  r_timer;
    logic [N_VOTERS-1:0] r_voted;
    logic [CNT_W-1:0]    r_yes, r_no;
    logic                r_pass, r_to;

    logic                w_in_collect;
    logic [N_VOTERS-1:0] w_new;
    logic [CNT_W-1:0]    w_yes_add, w_no_add, w_yes_n, w_no_n;
    logic                w_pass_hit, w_fail_hit, w_tmo_hit, w_decide;

    assign w_in_collect = (r_state == COLLECT);
    // Only first-time voters count, and only while a session is open.
    assign w_new = vote_req & ~r_voted & {N_VOTERS{w_in_collect}};

    vote_popcount #(.W(N_VOTERS)) u_yes_pop (
        .i_vec (w_new & vote_yes),
        .o_cnt (w_yes_add)
    );

    vote_popcount #(.W(N_VOTERS)) u_no_pop (
        .i_vec (w_new & ~vote_yes),
        .o_cnt (w_no_add)
    );

    // Decision looks at the counts as they will be after this edge.
    assign w_yes_n    = r_yes + w_yes_add;
    assign w_no_n     = r_no + w_no_add;
    assign w_pass_hit = (w_yes_n >= THR);
    assign w_fail_hit = (w_no_n > NO_MAX);
    assign w_tmo_hit  = (r_timer == T_LAST);
    assign w_decide   = w_in_collect && (w_pass_hit || w_fail_hit || w_tmo_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (start) w_state_n = COLLECT;
            COLLECT: begin
                if (start)         w_state_n = COLLECT;
                else if (w_decide) w_state_n = DONE;
            end
            DONE:    if (start) w_state_n = COLLECT;
            default: w_state_n = IDLE;
        endcase
    end

    // start wins over any votes presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_voted <= '0;
            r_yes   <= '0;
            r_no    <= '0;
            r_pass  <= 1'b0;
            r_to    <= 1'b0;
        end else if (start) begin
            r_timer <= '0;
            r_voted <= '0;
            r_yes   <= '0;
            r_no    <= '0;
            r_pass  <= 1'b0;
            r_to    <= 1'b0;
        end else if (w_in_collect) begin
            r_voted <= r_voted | w_new;
            r_yes   <= w_yes_n;
            r_no    <= w_no_n;
            if (w_decide) begin
                r_pass <= w_pass_hit;
                r_to   <= !w_pass_hit && !w_fail_hit;
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

    assign busy      = (r_state == COLLECT);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign timed_out = r_to;
    assign yes_cnt   = r_yes;
    assign no_cnt    = r_no;
    assign voted     = r_voted;

endmodule
